// File: rtl/pnc_stmc_dispatch_if.sv
// Packet-in / destination-beat-out handshake bundle for the PNC STMC dispatcher.
// master = packet source and beat sink, slave = dispatcher.
interface pnc_stmc_dispatch_if #(
  parameter int SLOT_W    = 7,
  parameter int NUM_SLOTS = 2
);
  localparam int PKT_W = 2 + NUM_SLOTS*SLOT_W;

  logic              in_valid;
  logic              in_ready;
  logic [PKT_W-1:0]  in_pkt;
  logic              out_valid;
  logic              out_ready;
  logic [SLOT_W-1:0] out_slot;
  logic [1:0]        out_kind;
  logic              out_last;

  modport master (
    output in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_slot, out_kind, out_last
  );
  modport slave (
    input  in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_slot, out_kind, out_last
  );
endinterface

// File: rtl/pnc_stmc_dispatch_unit.sv
// Spike/param packet dispatcher: one beat per valid destination slot, ascending order.
// Optional feature macro: PNC_STMC_DROP_CNT_EN (adds saturating null-packet drop_cnt).
module pnc_stmc_slot_lane #(
  parameter int SLOT_W = 7
) (
  input  logic [SLOT_W-1:0] slot_in,
  input  logic [SLOT_W-1:0] slot_q,
  input  logic              sel,
  output logic              nz,
  output logic [SLOT_W-1:0] gated
);
  assign nz    = |slot_in;
  assign gated = sel ? slot_q : '0;
endmodule

module pnc_stmc_dispatch_unit #(
  parameter int SLOT_W    = 7,
  parameter int NUM_SLOTS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  pnc_stmc_dispatch_if.slave     bus,
  output logic [1:0]             ctrl,
  output logic                   busy
`ifdef PNC_STMC_DROP_CNT_EN
  , output logic [15:0]          drop_cnt
`endif
);
  localparam int PKT_W = 2 + NUM_SLOTS*SLOT_W;
  localparam logic [NUM_SLOTS-1:0] ONE = NUM_SLOTS'(1);

  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_d;

  logic [NUM_SLOTS-1:0][SLOT_W-1:0] slots_in, slots_q, gated;
  logic [NUM_SLOTS-1:0]             nz, mask_q, mask_d, sel;
  logic [1:0]                       kind_q, kind_d, ctrl_d;
  logic                             accept, multi;

  assign slots_in = bus.in_pkt[NUM_SLOTS*SLOT_W-1:0];
  // One-hot of the lowest remaining destination; drives the output mux.
  assign sel      = mask_q & (~mask_q + ONE);
  assign multi    = |(mask_q & (mask_q - ONE));

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
    pnc_stmc_slot_lane #(.SLOT_W(SLOT_W)) u_lane (
      .slot_in (slots_in[i]),
      .slot_q  (slots_q[i]),
      .sel     (sel[i]),
      .nz      (nz[i]),
      .gated   (gated[i])
    );
  end

  always_comb begin
    bus.out_slot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) bus.out_slot = bus.out_slot | gated[i];
  end

  assign bus.out_kind = busy ? kind_q : 2'b00;
  assign bus.out_last = busy && !multi;

  always_comb begin
    state_d       = state;
    mask_d        = mask_q;
    kind_d        = kind_q;
    ctrl_d        = ctrl;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept = 1'b1;
          // param/richclub always route to slot 0, even a null slot 0.
          if (bus.in_pkt[PKT_W-1]) begin
            mask_d = ONE; kind_d = 2'b01; ctrl_d = 2'b01; state_d = EMIT;
          end else if (bus.in_pkt[PKT_W-2]) begin
            mask_d = ONE; kind_d = 2'b10; ctrl_d = 2'b01; state_d = EMIT;
          end else if (|nz) begin
            mask_d  = nz;
            kind_d  = 2'b11;
            ctrl_d  = |(nz & (nz - ONE)) ? 2'b11 : 2'b01;
            state_d = EMIT;
          end else begin
            ctrl_d = 2'b00;
          end
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
        if (bus.out_ready) begin
          mask_d = mask_q & ~sel;
          if (!multi) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '0;
      kind_q  <= 2'b00;
      slots_q <= '0;
      ctrl    <= 2'b10;
    end else begin
      mask_q <= mask_d;
      kind_q <= kind_d;
      ctrl   <= ctrl_d;
      if (accept) slots_q <= slots_in;
    end
  end

`ifdef PNC_STMC_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (accept && ctrl_d == 2'b00 && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_pnc_stmc_dispatch_unit.sv
// Bench for pnc_stmc_dispatch_unit: directed spec scenarios plus random traffic vs a beat-queue model.
module tb_pnc_stmc_dispatch_unit;
  logic clk, rst;
  logic [1:0] ctrl;
  logic busy;
`ifdef PNC_STMC_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  pnc_stmc_dispatch_if #(.SLOT_W(7), .NUM_SLOTS(2)) bus ();

  pnc_stmc_dispatch_unit #(.SLOT_W(7), .NUM_SLOTS(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .ctrl (ctrl),
    .busy (busy)
`ifdef PNC_STMC_DROP_CNT_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] slot;
    logic [1:0] kind;
    logic       last;
  } beat_t;

  beat_t       q[$];
  logic [1:0]  m_ctrl = 2'b10;
  int          m_drop = 0;
  bit          started = 0;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each accepted packet becomes the list of beats it must produce.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ctrl  = 2'b10;
      m_drop  = 0;
      started = 1;
    end else if (q.size() > 0) begin
      if (bus.out_ready) void'(q.pop_front());
    end else if (bus.in_valid) begin
      logic [15:0] p;
      logic [6:0]  s[2];
      int          cnt;
      p = bus.in_pkt;
      s[0] = p[6:0];
      s[1] = p[13:7];
      if (p[15]) begin
        q.push_back('{slot: s[0], kind: 2'b01, last: 1'b1});
        m_ctrl = 2'b01;
      end else if (p[14]) begin
        q.push_back('{slot: s[0], kind: 2'b10, last: 1'b1});
        m_ctrl = 2'b01;
      end else begin
        cnt = 0;
        for (int i = 0; i < 2; i++)
          if (s[i] != 0) begin
            q.push_back('{slot: s[i], kind: 2'b11, last: 1'b0});
            cnt++;
          end
        if (cnt == 0) begin
          m_ctrl = 2'b00;
          if (m_drop < 65535) m_drop++;
        end else begin
          q[q.size()-1].last = 1'b1;
          m_ctrl = (cnt == 1) ? 2'b01 : 2'b11;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready", bus.in_ready, q.size() == 0);
      chk("m_busy", busy, q.size() != 0);
      chk("m_out_valid", bus.out_valid, q.size() != 0);
      chk("m_ctrl", ctrl, m_ctrl);
      if (q.size() > 0) begin
        chk("m_out_slot", bus.out_slot, q[0].slot);
        chk("m_out_kind", bus.out_kind, q[0].kind);
        chk("m_out_last", bus.out_last, q[0].last);
      end
`ifdef PNC_STMC_DROP_CNT_EN
      chk("m_drop_cnt", drop_cnt, m_drop);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_pkt = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", ctrl, 2'b10);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_slot", bus.out_slot, 0);
    rst = 1'b0;
    cyc();

    // param packet
    bus.in_valid = 1; bus.in_pkt = 16'h8005; bus.out_ready = 1;
    cyc(); bus.in_valid = 0;
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_slot", bus.out_slot, 5);
    chk("t2_kind", bus.out_kind, 2'b01);
    chk("t2_last", bus.out_last, 1);
    chk("t2_ctrl", ctrl, 2'b01);
    chk("t2_in_ready_busy", bus.in_ready, 0);
    cyc();
    chk("t2_in_ready_back", bus.in_ready, 1);

    // two destinations with backpressure
    bus.in_valid = 1; bus.in_pkt = 16'h0283; bus.out_ready = 0;
    cyc(); bus.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_slot", bus.out_slot, 3);
      chk("t3_hold_last", bus.out_last, 0);
      cyc();
    end
    chk("t3_slot3", bus.out_slot, 3);
    chk("t3_ctrl", ctrl, 2'b11);
    bus.out_ready = 1;
    cyc();
    chk("t3_slot5", bus.out_slot, 5);
    chk("t3_last5", bus.out_last, 1);
    chk("t3_kind", bus.out_kind, 2'b11);
    cyc();
    chk("t3_done", bus.out_valid, 0);

    // zero slot 0 skipped
    bus.in_valid = 1; bus.in_pkt = 16'h0280;
    cyc(); bus.in_valid = 0;
    chk("t4_slot", bus.out_slot, 5);
    chk("t4_kind", bus.out_kind, 2'b11);
    chk("t4_last", bus.out_last, 1);
    chk("t4_ctrl", ctrl, 2'b01);
    cyc();

    // null packet
    bus.in_valid = 1; bus.in_pkt = 16'h0000;
    cyc(); bus.in_valid = 0;
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_ctrl", ctrl, 2'b00);
    chk("t5_in_ready", bus.in_ready, 1);
`ifdef PNC_STMC_DROP_CNT_EN
    chk("t5_drop1", drop_cnt, 1);
    bus.in_valid = 1;
    repeat (65537) cyc();
    bus.in_valid = 0;
    chk("t5_drop_sat", drop_cnt, 16'hFFFF);
`endif
    cyc();

    // reset mid-emit
    bus.in_valid = 1; bus.in_pkt = 16'h0283; bus.out_ready = 1;
    cyc(); bus.in_valid = 0;
    chk("t6_first", bus.out_slot, 3);
    cyc();
    chk("t6_second_pending", bus.out_slot, 5);
    rst = 1;
    cyc();
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_ctrl", ctrl, 2'b10);
    chk("t6_in_ready", bus.in_ready, 1);
    rst = 0;
    cyc();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] p;
      p = '0;
      p[15] = ($urandom_range(7) == 0);
      p[14] = ($urandom_range(7) == 0);
      for (int i = 0; i < 2; i++)
        p[i*7 +: 7] = ($urandom_range(2) == 0) ? 7'd0 : 7'($urandom);
      bus.in_pkt    = p;
      bus.in_valid  = ($urandom_range(9) < 7);
      bus.out_ready = ($urandom_range(9) < 6);
      rst           = ($urandom_range(199) == 0);
      cyc();
    end
    rst = 0; bus.in_valid = 0; bus.out_ready = 1;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
